// File: rtl/hex_display_pkg.sv
// Shared constants for the multiplexed hex display: font table, segment
// bit positions within {a,b,c,d,e,f,g,dp}, and the per-slot ghost-blank length.
package hex_display_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  // Anodes stay dark for this many cycles at the start of each digit slot
  localparam int GHOST_BLANK_CYCLES = 2;

  // Glyphs laid out as {a,b,c,d,e,f,g,dp}; dp is always 0 here
  localparam logic [7:0] HEX_FONT [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational hex glyph lookup: one nibble in, segments a..g out (a = MSB).
module hex_seg_decoder
  import hex_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_FONT[i_nibble][SEG_A:SEG_G];

endmodule

// File: rtl/hex_scan_display.sv
// Time-multiplexed hex display driver with per-frame input snapshot, PWM
// brightness and ghost blanking. Define HEX_SCAN_LZB_EN to blank leading zeros.
module hex_scan_display
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int PRESCALE_LOG2 = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   i_data,
  input  logic [NUM_DIGITS-1:0]     i_dp,
  input  logic [3:0]                i_bright,
  output logic [NUM_DIGITS-1:0]     o_anodes,
  output logic [7:0]                o_segments,
  output logic                      o_frame
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRESCALE_LOG2-1:0] PRESC_MAX = '1;
  localparam logic [PRESCALE_LOG2-1:0] BLANK_END = PRESCALE_LOG2'(GHOST_BLANK_CYCLES);

  logic                      run_q, run_d;
  logic [PRESCALE_LOG2-1:0]  presc_q, presc_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]   data_sh_q, data_sh_d;
  logic [NUM_DIGITS-1:0]     dp_sh_q, dp_sh_d;
  logic [3:0]                bright_sh_q, bright_sh_d;
  logic [NUM_DIGITS-1:0]     anodes_q, anodes_d;
  logic [7:0]                segments_q, segments_d;
  logic                      frame_q, frame_d;

  logic       slot_end;
  logic       frame_end;
  logic [3:0] cur_nibble;
  logic [6:0] cur_font;
  logic [3:0] phase;
  logic       lit;
  logic       lead_zero;

  // run_q is low for the single startup edge after reset, where the first
  // snapshot is taken while the scan state holds at index 0, slot start.
  always_comb begin
    slot_end    = (presc_q == PRESC_MAX);
    frame_end   = slot_end && (idx_q == LAST_IDX);
    run_d       = 1'b1;
    presc_d     = run_q ? presc_q + 1'b1 : '0;
    idx_d       = idx_q;
    data_sh_d   = data_sh_q;
    dp_sh_d     = dp_sh_q;
    bright_sh_d = bright_sh_q;
    if (run_q && slot_end) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
    if (!run_q || frame_end) begin
      data_sh_d   = i_data;
      dp_sh_d     = i_dp;
      bright_sh_d = i_bright;
    end
  end

  assign cur_nibble = data_sh_q[{idx_q, 2'b00} +: 4];

  hex_seg_decoder u_decoder (
    .i_nibble (cur_nibble),
    .o_seg    (cur_font)
  );

  always_comb begin
    phase = presc_q[PRESCALE_LOG2-1 -: 4];
    lit   = (phase <= bright_sh_q) && (presc_q >= BLANK_END);
`ifdef HEX_SCAN_LZB_EN
    lead_zero = (idx_q != '0) && ((data_sh_q >> {idx_q, 2'b00}) == '0);
`else
    lead_zero = 1'b0;
`endif
    anodes_d   = '1;
    segments_d = '0;
    frame_d    = 1'b0;
    if (run_q) begin
      segments_d[SEG_A:SEG_G] = lead_zero ? 7'd0 : cur_font;
      segments_d[SEG_DP]      = dp_sh_q[idx_q];
      if (lit) begin
        anodes_d = ~(NUM_DIGITS'(1) << idx_q);
      end
      frame_d = (presc_q == '0) && (idx_q == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q       <= 1'b0;
      presc_q     <= '0;
      idx_q       <= '0;
      data_sh_q   <= '0;
      dp_sh_q     <= '0;
      bright_sh_q <= '0;
      anodes_q    <= '1;
      segments_q  <= '0;
      frame_q     <= 1'b0;
    end else begin
      run_q       <= run_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      data_sh_q   <= data_sh_d;
      dp_sh_q     <= dp_sh_d;
      bright_sh_q <= bright_sh_d;
      anodes_q    <= anodes_d;
      segments_q  <= segments_d;
      frame_q     <= frame_d;
    end
  end

  assign o_anodes   = anodes_q;
  assign o_segments = segments_q;
  assign o_frame    = frame_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Bench for hex_scan_display: three instances (4 digits fast, 4 digits slow
// PWM, 3 digits), a cycle-count reference model, a vector table and sequences.
module tb_hex_scan_display;

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] seg;
    logic       fr;
  } out_t;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  br;
    int          digit;
    logic [3:0]  an;
    logic [7:0]  seg;
  } vec_t;

  localparam out_t IDLE = '{an: 8'hFF, seg: 8'h00, fr: 1'b0};
  localparam int N_OF [3] = '{4, 4, 3};
  localparam int P_OF [3] = '{4, 8, 4};
  localparam logic [7:0] FONT_TB [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };
`ifdef HEX_SCAN_LZB_EN
  localparam logic [7:0] LZ_SEG = 8'h00;
`else
  localparam logic [7:0] LZ_SEG = 8'hFC;
`endif

  logic clk;
  logic rst;
  logic [15:0] main_data;
  logic [3:0]  main_dp, main_br, main_an;
  logic [7:0]  main_seg;
  logic        main_fr;
  logic [15:0] pwm_data;
  logic [3:0]  pwm_dp, pwm_br, pwm_an;
  logic [7:0]  pwm_seg;
  logic        pwm_fr;
  logic [11:0] odd_data;
  logic [2:0]  odd_dp, odd_an;
  logic [3:0]  odd_br;
  logic [7:0]  odd_seg;
  logic        odd_fr;

  int vectors;
  int miscompares;
  logic check_en;

  hex_scan_display #(.NUM_DIGITS(4), .PRESCALE_LOG2(4)) dut_main (
    .clk(clk), .rst(rst), .i_data(main_data), .i_dp(main_dp), .i_bright(main_br),
    .o_anodes(main_an), .o_segments(main_seg), .o_frame(main_fr));

  hex_scan_display #(.NUM_DIGITS(4), .PRESCALE_LOG2(8)) dut_pwm (
    .clk(clk), .rst(rst), .i_data(pwm_data), .i_dp(pwm_dp), .i_bright(pwm_br),
    .o_anodes(pwm_an), .o_segments(pwm_seg), .o_frame(pwm_fr));

  hex_scan_display #(.NUM_DIGITS(3), .PRESCALE_LOG2(4)) dut_odd (
    .clk(clk), .rst(rst), .i_data(odd_data), .i_dp(odd_dp), .i_bright(odd_br),
    .o_anodes(odd_an), .o_segments(odd_seg), .o_frame(odd_fr));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] in_data [3];
  logic [7:0]  in_dp [3];
  logic [3:0]  in_br [3];
  out_t        act [3];

  assign in_data[0] = {16'd0, main_data};
  assign in_data[1] = {16'd0, pwm_data};
  assign in_data[2] = {20'd0, odd_data};
  assign in_dp[0]   = {4'd0, main_dp};
  assign in_dp[1]   = {4'd0, pwm_dp};
  assign in_dp[2]   = {5'd0, odd_dp};
  assign in_br[0]   = main_br;
  assign in_br[1]   = pwm_br;
  assign in_br[2]   = odd_br;
  assign act[0]     = '{an: {4'd0, main_an}, seg: main_seg, fr: main_fr};
  assign act[1]     = '{an: {4'd0, pwm_an},  seg: pwm_seg,  fr: pwm_fr};
  assign act[2]     = '{an: {5'd0, odd_an},  seg: odd_seg,  fr: odd_fr};

  // Output expected for cycle j counted from the start of the first frame
  function automatic out_t model_out(input int n, input int plog, input int j,
                                     input logic [31:0] data, input logic [7:0] dp,
                                     input logic [3:0] br);
    out_t r;
    int s, p, d, phase;
    logic [3:0] nib;
    logic [7:0] f;
    logic blank;
    s     = 1 << plog;
    p     = j % s;
    d     = (j / s) % n;
    phase = p / (s / 16);
    nib   = data[4*d +: 4];
    f     = FONT_TB[nib];
    blank = 1'b0;
`ifdef HEX_SCAN_LZB_EN
    blank = (d != 0) && ((data >> (4*d)) == 32'd0);
`endif
    r.seg = blank ? {7'd0, dp[d]} : {f[7:1], dp[d]};
    r.an  = (p >= 2 && phase <= int'(br)) ? ~(8'd1 << d) : 8'hFF;
    r.fr  = (j % (n * s)) == 0;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // k = edges since reset release; a frame snapshot is taken every N*2^P edges
  int          m_k [3];
  out_t        m_exp [3];
  logic [31:0] snap_data [3];
  logic [7:0]  snap_dp [3];
  logic [3:0]  snap_br [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_k[i]   <= 0;
        m_exp[i] <= IDLE;
      end else begin
        m_exp[i] <= (m_k[i] == 0) ? IDLE :
                    model_out(N_OF[i], P_OF[i], m_k[i] - 1, snap_data[i], snap_dp[i], snap_br[i]);
        if (m_k[i] % (N_OF[i] << P_OF[i]) == 0) begin
          snap_data[i] <= in_data[i];
          snap_dp[i]   <= in_dp[i];
          snap_br[i]   <= in_br[i];
        end
        m_k[i] <= m_k[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("model anodes[%0d]", i), {24'd0, act[i].an & ((8'd1 << N_OF[i]) - 8'd1)},
                    {24'd0, m_exp[i].an & ((8'd1 << N_OF[i]) - 8'd1)});
        checkOutput($sformatf("model segments[%0d]", i), {24'd0, act[i].seg}, {24'd0, m_exp[i].seg});
        checkOutput($sformatf("model frame[%0d]", i), {31'd0, act[i].fr}, {31'd0, m_exp[i].fr});
      end
    end
  end

  task automatic restart();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // After release at a negedge, the i-th following negedge shows cycle j = i-2
  task automatic applyStimulus(input vec_t v);
    main_data = v.data;
    main_dp   = v.dp;
    main_br   = v.br;
    restart();
    repeat (v.digit * 16 + 10) @(negedge clk);
  endtask

  vec_t tbl [14];
  int   first_fr, second_fr, fr_count, low_count;
  int   pwm_levels [3];
  int   pwm_expect [3];

  initial begin
    tbl[0]  = '{16'h1234, 4'h0, 4'hF, 0, 4'b1110, 8'h66};
    tbl[1]  = '{16'h1234, 4'h0, 4'hF, 1, 4'b1101, 8'hF2};
    tbl[2]  = '{16'h1234, 4'h0, 4'hF, 2, 4'b1011, 8'hDA};
    tbl[3]  = '{16'h1234, 4'h0, 4'hF, 3, 4'b0111, 8'h60};
    tbl[4]  = '{16'hABCD, 4'h0, 4'hF, 3, 4'b0111, 8'hEE};
    tbl[5]  = '{16'hABCD, 4'h0, 4'hF, 0, 4'b1110, 8'h7A};
    tbl[6]  = '{16'h0050, 4'h0, 4'hF, 3, 4'b0111, LZ_SEG};
    tbl[7]  = '{16'h0050, 4'h0, 4'hF, 2, 4'b1011, LZ_SEG};
    tbl[8]  = '{16'h0050, 4'h0, 4'hF, 1, 4'b1101, 8'hB6};
    tbl[9]  = '{16'h0050, 4'h0, 4'hF, 0, 4'b1110, 8'hFC};
    tbl[10] = '{16'h1234, 4'h0, 4'h7, 1, 4'b1111, 8'hF2};
    tbl[11] = '{16'h89EF, 4'h5, 4'hF, 2, 4'b1011, 8'hF7};
    tbl[12] = '{16'h89EF, 4'h5, 4'hF, 0, 4'b1110, 8'h8F};
    tbl[13] = '{16'h5678, 4'h0, 4'h0, 1, 4'b1111, 8'hE0};
    pwm_levels = '{3, 15, 0};
    pwm_expect = '{62, 254, 14};

    vectors = 0;
    miscompares = 0;
    check_en = 1'b0;
    for (int i = 0; i < 3; i++) m_exp[i] = IDLE;
    rst = 1'b1;
    main_data = 16'h1234; main_dp = 4'h0; main_br = 4'hF;
    pwm_data  = 16'h1234; pwm_dp  = 4'h0; pwm_br  = 4'h3;
    odd_data  = 12'h321;  odd_dp  = 3'b010; odd_br = 4'hF;

    @(negedge clk);
    check_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("reset anodes", {28'd0, main_an}, 32'hF);
      checkOutput("reset segments", {24'd0, main_seg}, 32'h0);
      checkOutput("reset frame", {31'd0, main_fr}, 32'h0);
    end

    for (int t = 0; t < 14; t++) begin
      applyStimulus(tbl[t]);
      checkOutput($sformatf("table %0d anodes", t), {28'd0, main_an}, {28'd0, tbl[t].an});
      checkOutput($sformatf("table %0d segments", t), {24'd0, main_seg}, {24'd0, tbl[t].seg});
    end

    main_data = 16'h1234; main_dp = 4'h0; main_br = 4'hF;
    restart();
    first_fr = -1; second_fr = -1; fr_count = 0;
    for (int i = 1; i <= 140; i++) begin
      @(negedge clk);
      if (main_fr) begin
        fr_count++;
        if (first_fr < 0) first_fr = i;
        else if (second_fr < 0) second_fr = i;
      end
    end
    checkOutput("first frame pulse position", first_fr, 2);
    checkOutput("frame pulse count", fr_count, 3);
    checkOutput("frame period", second_fr - first_fr, 64);

    restart();
    repeat (20) @(negedge clk);
    main_data = 16'hABCD;
    repeat (38) @(negedge clk);
    checkOutput("snapshot old digit3 seg", {24'd0, main_seg}, 32'h60);
    checkOutput("snapshot old digit3 an", {28'd0, main_an}, 32'h7);
    repeat (16) @(negedge clk);
    checkOutput("snapshot new digit0 seg", {24'd0, main_seg}, 32'h7A);
    repeat (48) @(negedge clk);
    checkOutput("snapshot new digit3 seg", {24'd0, main_seg}, 32'hEE);

    for (int b = 0; b < 3; b++) begin
      pwm_br = 4'(pwm_levels[b]);
      restart();
      low_count = 0;
      for (int i = 1; i <= 257; i++) begin
        @(negedge clk);
        if (pwm_an != 4'hF) low_count++;
      end
      checkOutput($sformatf("pwm low cycles br=%0d", pwm_levels[b]), low_count, pwm_expect[b]);
    end

    restart();
    repeat (26) @(negedge clk);
    checkOutput("odd digit1 an", {29'd0, odd_an}, 32'h5);
    checkOutput("odd digit1 seg with dp", {24'd0, odd_seg}, 32'hDB);
    repeat (16) @(negedge clk);
    checkOutput("odd digit2 an", {29'd0, odd_an}, 32'h3);
    checkOutput("odd digit2 seg", {24'd0, odd_seg}, 32'hF2);
    repeat (8) @(negedge clk);
    checkOutput("odd frame after wrap", {31'd0, odd_fr}, 32'h1);
    repeat (8) @(negedge clk);
    checkOutput("odd wrapped to digit0 an", {29'd0, odd_an}, 32'h6);
    checkOutput("odd wrapped digit0 seg", {24'd0, odd_seg}, 32'h60);

    restart();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      if ($urandom_range(0, 15) == 0) begin
        main_data = 16'($urandom) >> (4 * $urandom_range(0, 3));
        main_dp   = 4'($urandom);
        main_br   = 4'($urandom);
        pwm_data  = 16'($urandom) >> (4 * $urandom_range(0, 3));
        pwm_dp    = 4'($urandom);
        pwm_br    = 4'($urandom);
        odd_data  = 12'($urandom) >> (4 * $urandom_range(0, 2));
        odd_dp    = 3'($urandom);
        odd_br    = 4'($urandom);
      end
    end

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hex_scan_display.md
HEX_SCAN_DISPLAY -- requirements
Module: hex_scan_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, meaning the number of multiplexed digits (legal 2..8).
REQ-002 SHALL have parameter PRESCALE_LOG2, default 12, meaning digit slot length = 2^PRESCALE_LOG2 clk cycles (legal 4..24).
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset: synchronous, active-high.
REQ-005 SHALL have port i_data  input  4*NUM_DIGITS  hex nibbles; digit k = i_data[4k+3:4k], digit 0 rightmost.
REQ-006 SHALL have port i_dp  input  NUM_DIGITS  decimal point per digit, 1 = lit.
REQ-007 SHALL have port i_bright  input  4  brightness level 0..15.
REQ-008 SHALL have port o_anodes  output  NUM_DIGITS  digit select, active-low, registered.
REQ-009 SHALL have port o_segments  output  8  {a,b,c,d,e,f,g,dp}, bit7 = a, active-high, registered.
REQ-010 SHALL have port o_frame  output  1  one-cycle pulse at each frame start, registered.

Function
REQ-011 SHALL keep a free-running prescaler of PRESCALE_LOG2 bits, incrementing every cycle and wrapping to 0.
REQ-012 SHALL advance the digit index on prescaler wrap: 0,1,...,NUM_DIGITS-1, then 0; no other index values ever reached, including for non-power-of-two NUM_DIGITS.
REQ-013 SHALL snapshot i_data, i_dp, i_bright into shadow registers in the cycle the index wraps NUM_DIGITS-1 -> 0; input changes mid-frame SHALL NOT affect the displayed frame.
REQ-014 SHALL pulse o_frame for exactly one cycle, in the cycle the first outputs of a new frame appear.
REQ-015 SHALL decode the shadow nibble of the current index to segments a..g per hex font: 0=FC,1=60,2=DA,3=F2,4=66,5=B6,6=BE,7=E0,8=FE,9=F6,A=EE,b=3E,C=9C,d=7A,E=9E,F=8E (dp bit 0), then OR in shadow dp.
REQ-016 SHALL define PWM phase = prescaler top 4 bits; selected anode driven low only while phase <= shadow brightness, else all anodes high.
REQ-017 SHALL give brightness 15 full duty (16/16) and brightness 0 duty 1/16; display never fully dark via brightness.
REQ-018 SHALL drive at most one anode low in any cycle.
REQ-019 SHALL present o_anodes/o_segments with exactly one cycle latency from prescaler/index state; both update in the same cycle.
REQ-020 SHALL blank (all anodes high) for the first 2 cycles of every digit slot to suppress ghosting.

Reset
REQ-021 SHALL, while rst is high at a clock edge, clear prescaler, index, shadow registers; o_anodes = all ones, o_segments = 0, o_frame = 0.
REQ-022 SHALL, on the first edge after rst deasserts, snapshot inputs and start a frame at index 0; o_frame pulses once in the first output cycle.
REQ-023 SHALL honour rst asserted mid-slot or mid-frame identically, with no partial-state carry-over.

Configuration
REQ-024 SHALL, with macro HEX_SCAN_LZB_EN defined, blank leading zeros: digits above the highest nonzero digit show segments a..g = 0 (dp still honoured); digit 0 always shown.
REQ-025 SHALL, without HEX_SCAN_LZB_EN, show all digits including leading zeros.

Structure
REQ-026 SHALL place the 16-entry font constants, segment bit positions and the ghost-blank length constant in shared package hex_display_pkg.
REQ-027 SHALL implement the font lookup as combinational sub-module hex_seg_decoder (nibble in, 7 segments out).

Verification
REQ-028 SHALL check reset: rst held 3 cycles -> o_anodes = 4'b1111, o_segments = 0, o_frame = 0 throughout.
REQ-029 SHALL check scan: NUM_DIGITS=4, PRESCALE_LOG2=4, i_data=16'h1234, i_bright=15 -> anodes cycle 1110,1101,1011,0111 every 16 cycles with segments 66,F2,DA,60; o_frame period 64 cycles.
REQ-030 SHALL check snapshot: i_data changed 16'h1234 -> 16'hABCD mid-frame -> old values until next o_frame, then EE at digit 3 ... 7A at digit 0.
REQ-031 SHALL check PWM: i_bright=3, PRESCALE_LOG2=8 -> anode low 62 cycles per 256-cycle slot (64 minus 2 ghost-blank cycles).
REQ-032 SHALL check odd count and dp: NUM_DIGITS=3, i_dp=3'b010 -> index wraps 2->0, digit 1 segments have bit0 = 1.
REQ-033 SHALL check LZB: HEX_SCAN_LZB_EN defined, i_data=16'h0050 -> digits 3,2 segments 0, digit 1 = B6, digit 0 = FC; undefined -> digits 3,2 = FC.
